// File: rtl/vmem_lane_sequencer.sv
// Vector-lane memory sequencer: issues up to NUM_PORTS active lanes per granted cycle in
// ascending lane order, gathers load returns per lane, and pulses done once per request.
module vmem_lane_sequencer #(
  parameter int NUM_LANES = 4,
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          is_store,
  input  logic [NUM_LANES-1:0]          lane_mask,
  input  logic [NUM_LANES*ADDR_W-1:0]   lane_addr,
  input  logic [NUM_LANES*DATA_W-1:0]   store_data,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_LANES*DATA_W-1:0]   load_data,
  input  logic                          mem_gnt,
  output logic [NUM_PORTS-1:0]          mem_en,
  output logic [NUM_PORTS-1:0]          mem_we,
  output logic [NUM_PORTS*ADDR_W-1:0]   mem_addr,
  output logic [NUM_PORTS*DATA_W-1:0]   mem_wdata,
  input  logic [NUM_PORTS*DATA_W-1:0]   mem_rdata
);
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e                        state_q, state_d;
  logic                          store_q;
  logic [NUM_LANES-1:0]          pend_q, pend_d;
  logic [NUM_LANES*ADDR_W-1:0]   addr_q;
  logic [NUM_LANES*DATA_W-1:0]   wdata_q;
  logic [NUM_LANES*DATA_W-1:0]   load_q;
  logic [NUM_PORTS-1:0]          pipe_vld_q  [RD_LAT];
  logic [NUM_PORTS*LANE_W-1:0]   pipe_lane_q [RD_LAT];
  logic [NUM_PORTS*LANE_W-1:0]   issue_lane;
  logic                          accept;
  logic                          pipe_busy;

  assign accept    = (state_q == IDLE) && start;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign load_data = load_q;

  // A pending lane's rank among pending lanes selects its port; ranks beyond the port count wait.
  always_comb begin
    int rank;
    rank       = 0;
    pend_d     = pend_q;
    mem_en     = '0;
    mem_we     = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    issue_lane = '0;
    if (state_q == ISSUE && mem_gnt) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (pend_q[i]) begin
          for (int p = 0; p < NUM_PORTS; p++) begin
            if (rank == p) begin
              mem_en[p]                       = 1'b1;
              mem_we[p]                       = store_q;
              mem_addr[p*ADDR_W +: ADDR_W]    = addr_q[i*ADDR_W +: ADDR_W];
              mem_wdata[p*DATA_W +: DATA_W]   = wdata_q[i*DATA_W +: DATA_W];
              issue_lane[p*LANE_W +: LANE_W]  = LANE_W'(i);
              pend_d[i]                       = 1'b0;
            end
          end
          rank = rank + 1;
        end
      end
    end
  end

  // Entries in the final stage are captured this edge, so only earlier stages hold up DRAIN.
  always_comb begin
    pipe_busy = 1'b0;
    for (int k = 0; k < RD_LAT - 1; k++) begin
      pipe_busy = pipe_busy | (|pipe_vld_q[k]);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (lane_mask == '0) ? DONE : ISSUE;
      ISSUE:   if (mem_gnt && pend_d == '0) state_d = store_q ? DONE : DRAIN;
      DRAIN:   if (!pipe_busy) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_q <= 1'b0;
      pend_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      store_q <= is_store;
      pend_q  <= lane_mask;
      addr_q  <= lane_addr;
      wdata_q <= store_data;
    end else begin
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < RD_LAT; k++) begin
        pipe_vld_q[k]  <= '0;
        pipe_lane_q[k] <= '0;
      end
    end else begin
      pipe_vld_q[0]  <= mem_en & ~mem_we;
      pipe_lane_q[0] <= issue_lane;
      for (int k = 1; k < RD_LAT; k++) begin
        pipe_vld_q[k]  <= pipe_vld_q[k-1];
        pipe_lane_q[k] <= pipe_lane_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (accept && !is_store && lane_mask[i]) begin
          load_q[i*DATA_W +: DATA_W] <= '0;
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (pipe_vld_q[RD_LAT-1][p] &&
              pipe_lane_q[RD_LAT-1][p*LANE_W +: LANE_W] == LANE_W'(i)) begin
            load_q[i*DATA_W +: DATA_W] <= mem_rdata[p*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vmem_lane_sequencer.sv
// Bench for vmem_lane_sequencer: RD_LAT=1 and RD_LAT=3 instances driven in lockstep against
// a queue-based issue model, a reference memory image and a per-lane load register model.
module tb_vmem_lane_sequencer;
  localparam int NL = 4;
  localparam int NP = 2;
  localparam int AW = 12;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]         start;
  logic               is_store;
  logic [NL-1:0]      lane_mask;
  logic [NL*AW-1:0]   lane_addr;
  logic [NL*DW-1:0]   store_data;
  logic               mem_gnt;
  logic               busy [2];
  logic               done [2];
  logic [NL*DW-1:0]   load_data [2];
  logic [NP-1:0]      men [2];
  logic [NP-1:0]      mwe [2];
  logic [NP*AW-1:0]   maddr [2];
  logic [NP*DW-1:0]   mwdata [2];
  logic [NP*DW-1:0]   mrdata [2];

  vmem_lane_sequencer #(.NUM_LANES(NL), .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .start(start[0]), .is_store(is_store), .lane_mask(lane_mask),
    .lane_addr(lane_addr), .store_data(store_data), .busy(busy[0]), .done(done[0]),
    .load_data(load_data[0]), .mem_gnt(mem_gnt), .mem_en(men[0]), .mem_we(mwe[0]),
    .mem_addr(maddr[0]), .mem_wdata(mwdata[0]), .mem_rdata(mrdata[0]));

  vmem_lane_sequencer #(.NUM_LANES(NL), .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .start(start[1]), .is_store(is_store), .lane_mask(lane_mask),
    .lane_addr(lane_addr), .store_data(store_data), .busy(busy[1]), .done(done[1]),
    .load_data(load_data[1]), .mem_gnt(mem_gnt), .mem_en(men[1]), .mem_we(mwe[1]),
    .mem_addr(maddr[1]), .mem_wdata(mwdata[1]), .mem_rdata(mrdata[1]));

  // Memory per instance; read data emerges 1 (instance 0) or 3 (instance 1) cycles after mem_en.
  logic [DW-1:0]    mem [2][1<<AW];
  logic [NP*DW-1:0] rsr [2][3];
  bit               mem_ready;
  assign mrdata[0] = rsr[0][0];
  assign mrdata[1] = rsr[1][2];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int a = 0; a < (1<<AW); a++) begin
        mem[0][a] <= DW'(a + 256);
        mem[1][a] <= DW'(a + 256);
      end
      mem_ready <= 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < NP; p++) begin
          if (men[k][p] && mwe[k][p]) mem[k][maddr[k][p*AW +: AW]] <= mwdata[k][p*DW +: DW];
          rsr[k][0][p*DW +: DW] <= (men[k][p] && !mwe[k][p]) ? mem[k][maddr[k][p*AW +: AW]] : DW'($urandom);
        end
        rsr[k][1] <= rsr[k][0];
        rsr[k][2] <= rsr[k][1];
      end
    end
  end

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] ref_mem [1<<AW];
  logic [DW-1:0] ld_exp [NL];
  logic [AW-1:0] op_addr [NL];
  logic [DW-1:0] op_data [NL];
  bit            gnt_seq [64];

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_ops(input bit garbage);
    for (int i = 0; i < NL; i++) begin
      lane_addr[i*AW +: AW]  = garbage ? AW'($urandom) : op_addr[i];
      store_data[i*DW +: DW] = garbage ? DW'($urandom) : op_data[i];
    end
  endtask

  // mode 0: grant always; 1: no grant in cycles 1-3; 2: random grant (forced on from cycle 40)
  task automatic fill_gnt(input int mode);
    for (int c = 0; c < 64; c++) begin
      case (mode)
        0:       gnt_seq[c] = 1'b1;
        1:       gnt_seq[c] = !(c >= 1 && c <= 3);
        default: gnt_seq[c] = (c >= 40) ? 1'b1 : 1'(($urandom % 3) != 0);
      endcase
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_op(input bit st, input logic [NL-1:0] m);
    int pop, need, granted, last, maxd;
    int exp_done [2];
    int q[$];
    int plane [NP];
    logic [NP-1:0] en_exp;

    pop = $countones(m);
    need = (pop + NP - 1) / NP;
    granted = 0;
    last = 0;
    for (int c = 1; c < 64; c++) begin
      if (granted < need && gnt_seq[c]) begin
        granted++;
        last = c;
      end
    end
    exp_done[0] = (pop == 0) ? 1 : last + (st ? 0 : 1) + 1;
    exp_done[1] = (pop == 0) ? 1 : last + (st ? 0 : 3) + 1;
    maxd = exp_done[1];
    for (int i = 0; i < NL; i++) if (m[i]) q.push_back(i);

    start = 2'b11;
    is_store = st;
    lane_mask = m;
    drive_ops(1'b0);
    mem_gnt = gnt_seq[0];
    #1;
    for (int k = 0; k < 2; k++) begin
      chk_eq("busy_at_start", 64'(busy[k]), 64'd0);
      chk_eq("done_at_start", 64'(done[k]), 64'd0);
    end
    @(posedge clk); #1;

    for (int c = 1; c <= maxd; c++) begin
      mem_gnt = gnt_seq[c];
      for (int k = 0; k < 2; k++) start[k] = (c <= exp_done[k]) ? 1'($urandom_range(0, 1)) : 1'b0;
      is_store = 1'($urandom);
      lane_mask = NL'($urandom);
      drive_ops(1'b1);
      en_exp = '0;
      if (gnt_seq[c]) begin
        for (int p = 0; p < NP; p++) begin
          if (q.size() > 0) begin
            en_exp[p] = 1'b1;
            plane[p] = q.pop_front();
          end
        end
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        chk_eq("busy", 64'(busy[k]), 64'(c <= exp_done[k]));
        chk_eq("done", 64'(done[k]), 64'(c == exp_done[k]));
        chk_eq("mem_en", 64'(men[k]), 64'(en_exp));
        chk_eq("mem_we", 64'(mwe[k]), st ? 64'(en_exp) : 64'd0);
        for (int p = 0; p < NP; p++) begin
          if (en_exp[p]) begin
            chk_eq("mem_addr", 64'(maddr[k][p*AW +: AW]), 64'(op_addr[plane[p]]));
            if (st) chk_eq("mem_wdata", 64'(mwdata[k][p*DW +: DW]), 64'(op_data[plane[p]]));
          end
        end
        if (c == 1 && !st) begin
          for (int i = 0; i < NL; i++)
            chk_eq("load_clear", 64'(load_data[k][i*DW +: DW]), m[i] ? 64'd0 : 64'(ld_exp[i]));
        end
      end
      @(posedge clk); #1;
    end

    start = 2'b00;
    for (int i = 0; i < NL; i++) begin
      if (m[i]) begin
        if (st) ref_mem[op_addr[i]] = op_data[i];
        else    ld_exp[i] = ref_mem[op_addr[i]];
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk_eq("busy_after", 64'(busy[k]), 64'd0);
      for (int i = 0; i < NL; i++)
        chk_eq("load_data", 64'(load_data[k][i*DW +: DW]), 64'(ld_exp[i]));
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 2'b00;
    is_store = 1'b0;
    lane_mask = '0;
    lane_addr = '0;
    store_data = '0;
    mem_gnt = 1'b0;
    for (int a = 0; a < (1<<AW); a++) ref_mem[a] = DW'(a + 256);
    for (int i = 0; i < NL; i++) ld_exp[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk_eq("rst_busy", 64'(busy[k]), 64'd0);
      chk_eq("rst_done", 64'(done[k]), 64'd0);
      chk_eq("rst_en", 64'(men[k]), 64'd0);
      chk_eq("rst_we", 64'(mwe[k]), 64'd0);
      chk_eq("rst_addr", 64'(maddr[k]), 64'd0);
      chk_eq("rst_wdata", 64'(mwdata[k]), 64'd0);
      chk_eq("rst_load", 64'(|load_data[k]), 64'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Full-mask load, addresses 10..13.
    for (int i = 0; i < NL; i++) begin op_addr[i] = AW'(10 + i); op_data[i] = '0; end
    fill_gnt(0);
    run_op(1'b0, 4'b1111);
    chk_eq("full_load_lane0", 64'(load_data[0][0 +: DW]), 64'h10A);
    chk_eq("full_load_lane3", 64'(load_data[1][3*DW +: DW]), 64'h10D);

    // Sparse store to 20..23, only lanes 1 and 3.
    for (int i = 0; i < NL; i++) begin op_addr[i] = AW'(20 + i); op_data[i] = DW'($urandom); end
    op_data[1] = 32'hAAAA;
    op_data[3] = 32'hBBBB;
    run_op(1'b1, 4'b1010);

    // Grant stall on a full load of the same addresses.
    fill_gnt(1);
    run_op(1'b0, 4'b1111);
    chk_eq("stall_lane1", 64'(load_data[0][1*DW +: DW]), 64'hAAAA);
    chk_eq("stall_lane2", 64'(load_data[1][2*DW +: DW]), 64'h116);

    // Empty mask.
    fill_gnt(2);
    run_op(1'b0, 4'b0000);

    // Reset while a three-lane load is draining; lane 3 keeps its old value until reset.
    for (int i = 0; i < NL; i++) op_addr[i] = AW'(10 + i);
    start = 2'b11;
    is_store = 1'b0;
    lane_mask = 4'b0111;
    drive_ops(1'b0);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    start = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk_eq("midrst_busy", 64'(busy[k]), 64'd0);
      chk_eq("midrst_done", 64'(done[k]), 64'd0);
      chk_eq("midrst_en", 64'(men[k]), 64'd0);
      chk_eq("midrst_load", 64'(|load_data[k]), 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk_eq("late_rdata_dropped", 64'(|load_data[k]), 64'd0);
      chk_eq("idle_after_rst", 64'(busy[k]), 64'd0);
    end
    for (int i = 0; i < NL; i++) ld_exp[i] = '0;
    fill_gnt(0);
    run_op(1'b0, 4'b1111);

    // Randomized operations over a small address window so duplicates and reuse occur.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NL; i++) begin
        op_addr[i] = AW'($urandom_range(0, 15));
        op_data[i] = DW'($urandom);
      end
      fill_gnt(($urandom % 4 == 0) ? 0 : 2);
      run_op(1'($urandom), NL'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vmem_lane_sequencer.md
Name: vmem_lane_sequencer

Overview:
- Parametrised vector-lane memory sequencer between the vector coprocessor and the shared data memory.
- Generalises the fixed 4-lane, 4-port vector load/store path to NUM_LANES lanes served over NUM_PORTS memory ports.
- Adds a per-lane active mask, grant-based stalling (the protocol-controller or core port may take memory cycles) and configurable read latency.
- Collects load results into a per-lane register file and signals completion with a one-cycle done pulse.

Parameters:
- NUM_LANES, 4, number of vector lanes (>=1).
- NUM_PORTS, 2, memory ports usable per cycle (1..NUM_LANES).
- ADDR_W, 12, memory word-address width.
- DATA_W, 32, data word width.
- RD_LAT, 1, cycles from mem_en to valid mem_rdata (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  request pulse; accepted only when busy=0.
- is_store  in  1  1=store, 0=load; sampled with start.
- lane_mask  in  NUM_LANES  bit i=1 means lane i is active; sampled with start.
- lane_addr  in  NUM_LANES*ADDR_W  lane i address at [i*ADDR_W +: ADDR_W].
- store_data  in  NUM_LANES*DATA_W  lane i store word.
- busy  out  1  high from the cycle after start is accepted through the done cycle.
- done  out  1  one-cycle completion pulse.
- load_data  out  NUM_LANES*DATA_W  captured load words, held until the next accepted load.
- mem_gnt  in  1  memory grant; issue allowed only in cycles where mem_gnt=1.
- mem_en  out  NUM_PORTS  port p access enable.
- mem_we  out  NUM_PORTS  port p write enable.
- mem_addr  out  NUM_PORTS*ADDR_W  port p address.
- mem_wdata  out  NUM_PORTS*DATA_W  port p write data.
- mem_rdata  in  NUM_PORTS*DATA_W  port p read data, valid RD_LAT cycles after mem_en.

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE; pending mask, return pipeline and load_data are cleared to 0.
  - busy=0, done=0; mem_en, mem_we, mem_addr and mem_wdata are 0.
  - An access in flight is abandoned, and its data is not captured after reset releases.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 latches is_store, lane_mask, lane_addr and store_data.
  - Pending mask is set to lane_mask.
  - Next state is ISSUE, or DONE if lane_mask==0.
  - On an accepted load, load_data entries are cleared only for the lanes being loaded.
- start while busy=1: ignored, with no effect on the latched operands.
- ISSUE, each cycle with mem_gnt=1:
  - Up to NUM_PORTS lowest-indexed pending lanes are assigned to ports 0,1,... in ascending lane order.
  - Those lanes are cleared from pending.
  - mem_en=1 on used ports; mem_we=is_store on used ports; unused ports have en=we=0.
- ISSUE, mem_gnt=0: all mem_en=0 and pending is unchanged (stall, no timeout).
- Port outputs are combinational from state, pending and mem_gnt; there is no extra output register.
- Loads:
  - The issued lane index and valid bit per port travel through an RD_LAT-deep shift pipeline.
  - mem_rdata[p] is written into load_data[lane] at the clock edge ending cycle t+RD_LAT, where t is the issue cycle.
- ISSUE exit when pending becomes 0:
  - Store: go to DONE.
  - Load: go to DRAIN.
- DRAIN: wait until the return pipeline is empty (last capture completed), then go to DONE.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE; start is accepted again in the next cycle.
- Grant cycles needed = ceil(popcount(lane_mask)/NUM_PORTS). Total latency with mem_gnt held high, from the start cycle to the done cycle:
  - Store: grant cycles + 1.
  - Load: grant cycles + RD_LAT + 1.
- Masked-off lanes are never issued, and their load_data entries keep their previous values.
- Duplicate addresses across lanes are issued as-is, with no conflict detection. Same-cycle same-address stores resolve by memory semantics.

Test Plan:
- Full-mask load: NUM_LANES=4, NUM_PORTS=2, RD_LAT=1, mask=4'b1111, addrs 10/11/12/13, memory returns addr+0x100, mem_gnt=1.
  - Issue cycles 1-2 (lanes 0,1 then 2,3); done in cycle 4.
  - load_data = {0x10D,0x10C,0x10B,0x10A}.
- Store with sparse mask: mask=4'b1010, data lane1=0xAAAA, lane3=0xBBBB.
  - One issue cycle: port0 gets lane1, port1 gets lane3, we=11.
  - done in cycle 2; lanes 0 and 2 never appear on the ports.
- Grant stall: full-mask load with mem_gnt=0 in cycles 1-3, then 1.
  - No mem_en during cycles 1-3; issues occur in cycles 4-5; done in cycle 7; data correct.
- Edge cases:
  - mask=0 gives done in cycle 1 with no mem_en.
  - start asserted while busy is ignored.
  - RD_LAT=3 full load gives done in cycle 6.
- Reset mid-DRAIN: assert rst while a load is in flight.
  - Outputs go to 0 immediately; late mem_rdata is not captured.
  - A new start after reset completes normally.
